// File: rtl/alu_serial_seq.sv
// Operand sequencer for a 1-bit serial ALU: streams rs1/rs2 LSB-first,
// reassembles the registered alu_result stream and pulses done.
module alu_serial_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  input  logic [SHW-1:0]   shamt,
  output logic [2:0]       alu_op,
  output logic             alu_en,
  output logic             alu_start,
  output logic             rs1,
  output logic             rs2,
  input  logic             alu_result,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0]     OP_SLLI   = 3'b101;
  localparam logic [2:0]     OP_SRLI   = 3'b110;
  localparam logic [SHW-1:0] IDX_LAST  = SHW'(WIDTH - 1);
  localparam logic [SHW:0]   WIDTH_EXT = (SHW + 1)'(WIDTH);

  state_t           state_reg, state_next;
  logic [SHW-1:0]   idx_reg, shamt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [2:0]       op_reg;
  logic             cap_en_reg;
  logic             accept;
  logic [SHW-1:0]   idx_sub;
  logic [SHW:0]     idx_add;
  logic             rs1_bit;

  assign accept  = (state_reg == IDLE) && start && !flush;
  assign idx_sub = idx_reg - shamt_reg;
  assign idx_add = {1'b0, idx_reg} + {1'b0, shamt_reg};

  // Shifts are realised by offsetting the read index into A, zero-filling
  // positions that fall outside the operand.
  always_comb begin
    rs1_bit = a_reg[idx_reg];
    if (op_reg == OP_SLLI)
      rs1_bit = (idx_reg >= shamt_reg) ? a_reg[idx_sub] : 1'b0;
    else if (op_reg == OP_SRLI)
      rs1_bit = (idx_add < WIDTH_EXT) ? a_reg[idx_add[SHW-1:0]] : 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    alu_en     = 1'b0;
    alu_start  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        alu_en    = 1'b1;
        alu_start = (idx_reg == '0);
        if (idx_reg == IDX_LAST) state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort suppresses every strobe in the cycle it is seen.
    if (flush) begin
      state_next = IDLE;
      alu_en     = 1'b0;
      alu_start  = 1'b0;
      done       = 1'b0;
    end
  end

  assign rs1    = alu_en & rs1_bit;
  assign rs2    = alu_en & b_reg[idx_reg];
  assign alu_op = op_reg;
  assign result = result_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      shamt_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      cap_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // The ALU result lags its inputs by one cycle, so capture does too.
      cap_en_reg <= alu_en;
      if (accept) begin
        a_reg     <= op_a;
        b_reg     <= op_b;
        op_reg    <= op_sel;
        shamt_reg <= shamt;
        idx_reg   <= '0;
      end else if (alu_en) begin
        idx_reg <= idx_reg + SHW'(1);
      end
      if (cap_en_reg)
        result_reg <= {alu_result, result_reg[WIDTH-1:1]};
    end
  end

endmodule
